c8_to_512: RTL and testbench
============================

C8_TO_512 -- requirements
Module: c8_to_512

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 480, giving the output data word width (60 bytes).
REQ-002 SHALL have parameter CTRL_WIDTH, default 32, giving the output control word width.
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 16, giving the consecutive datavalid-low cycles that end a packet.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port data_in, input, 8 bits: stream byte.
REQ-007 SHALL have port datavalid, input, 1 bit: data_in is valid this cycle.
REQ-008 SHALL have port newpkt, input, 1 bit: the current byte is the first byte of a new packet; it is sampled only when datavalid=1.
REQ-009 SHALL have port out_wr, input/output direction output, 1 bit: one-cycle write strobe for out_data/out_ctl.
REQ-010 SHALL have port out_ctl, output, CTRL_WIDTH bits: word descriptor.
REQ-011 SHALL have port out_data, output, DATA_WIDTH bits: packed bytes.

Function
REQ-012 SHALL pack accepted bytes big-endian: the first byte of a word goes to out_data[479:472] and the 60th byte to out_data[7:0]; unfilled byte lanes SHALL be zero.
REQ-013 SHALL define out_ctl as: [31] SOP, [30] EOP, [29:24] valid byte count (1..60), [23:16] packet sequence number mod 256, [15:0] word index within the packet (starting at 0).
REQ-014 SHALL hold a filled 60-byte word internally and not emit it until its fate is known.
REQ-015 SHALL, when the next byte of the same packet arrives (datavalid=1, newpkt=0), emit the held word with EOP=0; that byte then starts the next word with count=1.
REQ-016 SHALL, when a newpkt byte arrives while any bytes are buffered, emit the buffered word with EOP=1; the newpkt byte starts a new word with SOP pending, and the sequence number increments.
REQ-017 SHALL, when datavalid is low for IDLE_TIMEOUT consecutive cycles and bytes are buffered, emit the buffered word with EOP=1 and empty the buffer.
REQ-018 SHALL treat a byte arriving with an empty buffer and newpkt=0 (after reset or timeout) as a packet start; the sequence number increments only on a packet start that follows a prior packet.
REQ-019 SHALL reset the datavalid-low counter to zero on every accepted byte; gaps shorter than IDLE_TIMEOUT SHALL NOT split the packet.
REQ-020 SHALL register all outputs: out_wr pulses high for exactly one cycle, in the cycle after the triggering byte or timeout edge.
REQ-021 SHALL hold out_data/out_ctl stable between writes.
REQ-022 SHALL allow an emit and a new-byte capture in the same cycle without data loss, sustaining one byte per clock indefinitely.
REQ-023 SHALL set SOP=1 only on word index 0 of each packet.
REQ-024 SHALL set both SOP and EOP for a packet of 60 bytes or fewer.
REQ-025 SHALL wrap the word index and sequence number modulo their field widths.

Reset
REQ-026 SHALL, while rst=1, asynchronously clear out_wr, out_ctl, out_data, the byte buffer, the byte count, the idle counter, the word index and the sequence number to 0.
REQ-027 SHALL discard any partial packet on reset, with no flush write.
REQ-028 SHALL accept the first byte in the first clock edge after rst deasserts.

Verification
REQ-029 Scenario: one 60-byte packet, bytes 0x00..0x3B, newpkt on the first byte, then idle -> exactly one out_wr IDLE_TIMEOUT+1 cycles after the last byte, with ctl SOP=1, EOP=1, count=60, seq=0, idx=0, out_data[479:472]=0x00 and [7:0]=0x3B.
REQ-030 Scenario: a 64-byte packet followed by a newpkt byte -> write 1 the cycle after byte 61 (SOP=1, EOP=0, count=60, idx=0), then write 2 the cycle after the newpkt byte (SOP=0, EOP=1, count=4, idx=1, data bytes in [479:448], rest zero).
REQ-031 Scenario: a 10-byte packet with 5-cycle datavalid gaps mid-packet -> no write until newpkt or timeout, then a single word with count=10.
REQ-032 Scenario: three back-to-back 1-byte packets (newpkt every cycle) followed by idle -> writes of count=1, SOP=EOP=1 with seq 0, 1, 2 in consecutive cycles (the last after timeout).
REQ-033 Scenario: rst asserted after 30 bytes of a packet -> all outputs 0 immediately with no write; the next packet starts with seq=0, idx=0.

Source files
------------

// File: rtl/c8_to_512.sv
// Byte-stream to wide-word packer: gathers 8-bit bytes into 60-byte big-endian words
// and tags each word with SOP/EOP, byte count, packet sequence number and word index.
module c8_to_512 #(
    parameter int unsigned DATA_WIDTH   = 480,
    parameter int unsigned CTRL_WIDTH   = 32,
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            data_in,
    input  logic                  datavalid,
    input  logic                  newpkt,
    output logic                  out_wr,
    output logic [CTRL_WIDTH-1:0] out_ctl,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic [15:0]           idx_q, idx_d;
    logic [7:0]            seq_q, seq_d;
    logic                  sop_q, sop_d;
    logic                  started_q, started_d;
    logic                  out_wr_q, out_wr_d;
    logic [CTRL_WIDTH-1:0] out_ctl_q, out_ctl_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    function automatic logic [CTRL_WIDTH-1:0] make_ctl(
        input logic             sop,
        input logic             eop,
        input logic [CNT_W-1:0] cnt,
        input logic [7:0]       seq,
        input logic [15:0]      idx
    );
        logic [31:0] c;
        c = {sop, eop, 6'(cnt), seq, idx};
        return CTRL_WIDTH'(c);
    endfunction

    // Next-state: a word is only emitted once the following byte, a newpkt or the idle timeout decides its EOP.
    always_comb begin
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        idx_d      = idx_q;
        seq_d      = seq_q;
        sop_d      = sop_q;
        started_d  = started_q;
        out_wr_d   = 1'b0;
        out_ctl_d  = out_ctl_q;
        out_data_d = out_data_q;

        if (datavalid) begin
            idle_d = '0;
            if (newpkt && cnt_q != '0) begin
                out_wr_d   = 1'b1;
                out_data_d = buf_q;
                out_ctl_d  = make_ctl(sop_q, 1'b1, cnt_q, seq_q, idx_q);
                buf_d      = {data_in, {(DATA_WIDTH-8){1'b0}}};
                cnt_d      = CNT_W'(1);
                seq_d      = seq_q + 8'd1;
                idx_d      = '0;
                sop_d      = 1'b1;
            end else if (cnt_q == CNT_W'(NBYTES)) begin
                out_wr_d   = 1'b1;
                out_data_d = buf_q;
                out_ctl_d  = make_ctl(sop_q, 1'b0, cnt_q, seq_q, idx_q);
                buf_d      = {data_in, {(DATA_WIDTH-8){1'b0}}};
                cnt_d      = CNT_W'(1);
                idx_d      = idx_q + 16'd1;
                sop_d      = 1'b0;
            end else begin
                // Empty buffer: this byte opens a packet even without newpkt.
                if (cnt_q == '0) begin
                    buf_d     = '0;
                    started_d = 1'b1;
                    idx_d     = '0;
                    sop_d     = 1'b1;
                    if (started_q) begin
                        seq_d = seq_q + 8'd1;
                    end
                end
                for (int unsigned i = 0; i < NBYTES; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        buf_d[DATA_WIDTH-8-8*i +: 8] = data_in;
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            if (idle_q != IDLE_W'(IDLE_TIMEOUT)) begin
                idle_d = idle_q + IDLE_W'(1);
            end
            if (idle_q == IDLE_W'(IDLE_TIMEOUT - 1) && cnt_q != '0) begin
                out_wr_d   = 1'b1;
                out_data_d = buf_q;
                out_ctl_d  = make_ctl(sop_q, 1'b1, cnt_q, seq_q, idx_q);
                buf_d      = '0;
                cnt_d      = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q      <= '0;
            cnt_q      <= '0;
            idle_q     <= '0;
            idx_q      <= '0;
            seq_q      <= '0;
            sop_q      <= 1'b0;
            started_q  <= 1'b0;
            out_wr_q   <= 1'b0;
            out_ctl_q  <= '0;
            out_data_q <= '0;
        end else begin
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            sop_q      <= sop_d;
            started_q  <= started_d;
            out_wr_q   <= out_wr_d;
            out_ctl_q  <= out_ctl_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_wr   = out_wr_q;
    assign out_ctl  = out_ctl_q;
    assign out_data = out_data_q;

endmodule

// File: tb/tb_c8_to_512.sv
// Bench for c8_to_512: directed scenarios with constant expectations plus randomized
// traffic checked against a queue-based packet model.
module tb_c8_to_512;

    localparam int unsigned DW = 480;
    localparam int unsigned CW = 32;
    localparam int unsigned TO = 16;
    localparam int unsigned NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    data_in;
    logic          datavalid;
    logic          newpkt;
    logic          out_wr;
    logic [CW-1:0] out_ctl;
    logic [DW-1:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    c8_to_512 #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .IDLE_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .datavalid(datavalid),
        .newpkt(newpkt), .out_wr(out_wr), .out_ctl(out_ctl), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Reference model: the current word is a byte queue; packets are tracked by counters.
    logic [7:0]  q_bytes[$];
    int          m_seq, m_idx, m_idle;
    bit          m_sop, m_started;
    logic        exp_wr;
    logic [31:0] exp_ctl;
    logic [DW-1:0] exp_data;

    function automatic void model_clear();
        q_bytes.delete();
        m_seq = 0; m_idx = 0; m_idle = 0; m_sop = 0; m_started = 0;
        exp_wr = 0; exp_ctl = '0; exp_data = '0;
    endfunction

    function automatic void model_emit(bit eop);
        exp_wr   = 1;
        exp_data = '0;
        for (int i = 0; i < q_bytes.size(); i++) exp_data[DW-1-8*i -: 8] = q_bytes[i];
        exp_ctl  = {m_sop, eop, 6'(q_bytes.size()), 8'(m_seq), 16'(m_idx)};
    endfunction

    function automatic void model_step(bit dv, bit np, logic [7:0] d);
        exp_wr = 0;
        if (dv) begin
            m_idle = 0;
            if (np && q_bytes.size() > 0) begin
                model_emit(1);
                q_bytes.delete(); q_bytes.push_back(d);
                m_seq++; m_idx = 0; m_sop = 1;
            end else if (q_bytes.size() == NB) begin
                model_emit(0);
                q_bytes.delete(); q_bytes.push_back(d);
                m_idx++; m_sop = 0;
            end else begin
                if (q_bytes.size() == 0) begin
                    if (m_started) m_seq++;
                    m_started = 1; m_idx = 0; m_sop = 1;
                end
                q_bytes.push_back(d);
            end
        end else begin
            m_idle++;
            if (m_idle == TO && q_bytes.size() > 0) begin
                model_emit(1);
                q_bytes.delete();
            end
        end
    endfunction

    // One clock: drive, let the edge happen, advance the model, settle for sampling.
    task automatic step(input bit dv, input bit np, input logic [7:0] d);
        datavalid = dv; newpkt = np; data_in = d;
        @(posedge clk);
        model_step(dv, np, d);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; datavalid = 0; newpkt = 0; data_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1; datavalid = 1; newpkt = 1; data_in = 8'hA5;
        #3;
        n_checks++;
        if (out_wr !== 1'b0 || out_ctl !== '0 || out_data !== '0) begin
            n_errors++;
            $display("FAIL reset_state wr=%b ctl=%h data=%h required zeros", out_wr, out_ctl, out_data);
        end
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(0, 0, 8'h00);
            n_checks++;
            if (out_wr !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_idle_wr cycle %0d got %b required 0", c, out_wr);
            end
        end
    endtask

    task automatic test_single60();
        int nwr, at;
        logic [31:0] got_ctl;
        logic [DW-1:0] got_data, want;
        do_reset();
        nwr = 0; at = 0; got_ctl = '0; got_data = '0; want = '0;
        for (int i = 0; i < 60; i++) begin
            step(1, i == 0, 8'(i));
            want[DW-1-8*i -: 8] = 8'(i);
            if (out_wr) nwr++;
        end
        for (int c = 1; c <= 30; c++) begin
            step(0, 0, 8'h00);
            if (out_wr) begin
                nwr++;
                if (at == 0) begin at = c; got_ctl = out_ctl; got_data = out_data; end
            end
        end
        n_checks++;
        if (nwr !== 1) begin n_errors++; $display("FAIL single60_count writes=%0d required 1", nwr); end
        n_checks++;
        if (at !== TO) begin n_errors++; $display("FAIL single60_timing idle cycle=%0d required %0d", at, TO); end
        n_checks++;
        if (got_ctl !== 32'hFC00_0000) begin n_errors++; $display("FAIL single60_ctl got %h required fc000000", got_ctl); end
        n_checks++;
        if (got_data[479:472] !== 8'h00 || got_data[7:0] !== 8'h3B || got_data !== want) begin
            n_errors++;
            $display("FAIL single60_data got %h required %h", got_data, want);
        end
    endtask

    task automatic test_64bytes();
        logic [7:0] b[64];
        logic [DW-1:0] w1, w2;
        int early;
        do_reset();
        w1 = '0; w2 = '0; early = 0;
        for (int i = 0; i < 64; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 60; i++) w1[DW-1-8*i -: 8] = b[i];
        for (int i = 0; i < 4; i++) w2[DW-1-8*i -: 8] = b[60+i];
        for (int i = 0; i < 60; i++) begin
            step(1, i == 0, b[i]);
            if (out_wr) early++;
        end
        step(1, 0, b[60]);
        n_checks++;
        if (out_wr !== 1'b1 || out_ctl !== 32'hBC00_0000 || out_data !== w1) begin
            n_errors++;
            $display("FAIL pkt64_word0 wr=%b ctl=%h required 1/bc000000 data=%h required %h", out_wr, out_ctl, out_data, w1);
        end
        for (int i = 61; i < 64; i++) begin
            step(1, 0, b[i]);
            if (out_wr) early++;
        end
        n_checks++;
        if (early !== 0) begin n_errors++; $display("FAIL pkt64_extra_writes got %0d required 0", early); end
        step(1, 1, 8'h77);
        n_checks++;
        if (out_wr !== 1'b1 || out_ctl !== 32'h4400_0001 || out_data !== w2) begin
            n_errors++;
            $display("FAIL pkt64_word1 wr=%b ctl=%h required 1/44000001 data=%h required %h", out_wr, out_ctl, out_data, w2);
        end
        step(0, 0, 8'h00);
        n_checks++;
        if (out_wr !== 1'b0 || out_ctl !== 32'h4400_0001) begin
            n_errors++;
            $display("FAIL pkt64_hold wr=%b ctl=%h required 0/44000001", out_wr, out_ctl);
        end
    endtask

    task automatic test_gaps();
        logic [DW-1:0] want;
        int nwr;
        do_reset();
        want = '0; nwr = 0;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            want[DW-1-8*i -: 8] = v;
            step(1, i == 0, v);
            if (out_wr) nwr++;
            if (i != 9) begin
                for (int g = 0; g < 5; g++) begin
                    step(0, 0, 8'h00);
                    if (out_wr) nwr++;
                end
            end
        end
        n_checks++;
        if (nwr !== 0) begin n_errors++; $display("FAIL gaps_split writes=%0d required 0", nwr); end
        step(1, 1, 8'h11);
        n_checks++;
        if (out_wr !== 1'b1 || out_ctl !== 32'hCA00_0000 || out_data !== want) begin
            n_errors++;
            $display("FAIL gaps_word wr=%b ctl=%h required 1/ca000000 data=%h required %h", out_wr, out_ctl, out_data, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want_ctl[3];
        int nwr;
        do_reset();
        want_ctl[0] = 32'hC100_0000; want_ctl[1] = 32'hC101_0000; want_ctl[2] = 32'hC102_0000;
        nwr = 0;
        for (int i = 0; i < 3 + TO + 4; i++) begin
            if (i < 3) step(1, 1, 8'(8'hB0 + i));
            else       step(0, 0, 8'h00);
            n_checks++;
            if (out_wr !== exp_wr || out_ctl !== exp_ctl || out_data !== exp_data) begin
                n_errors++;
                $display("FAIL b2b_model cycle %0d wr=%b/%b ctl=%h/%h", i, out_wr, exp_wr, out_ctl, exp_ctl);
            end
            if (out_wr === 1'b1) begin
                n_checks++;
                if (nwr > 2 || out_ctl !== want_ctl[nwr] || out_data[479:472] !== 8'(8'hB0 + nwr)) begin
                    n_errors++;
                    $display("FAIL b2b_write %0d ctl=%h byte=%h", nwr, out_ctl, out_data[479:472]);
                end
                nwr++;
            end
        end
        n_checks++;
        if (nwr !== 3) begin n_errors++; $display("FAIL b2b_count writes=%0d required 3", nwr); end
    endtask

    task automatic test_reset_mid();
        int nwr;
        do_reset();
        step(1, 1, 8'h01); step(1, 0, 8'h02);
        for (int i = 0; i < 30; i++) step(1, i == 0, 8'(i + 3));
        #2 rst = 1;
        #1;
        n_checks++;
        if (out_wr !== 1'b0 || out_ctl !== '0 || out_data !== '0) begin
            n_errors++;
            $display("FAIL resetmid_clear wr=%b ctl=%h data=%h required zeros", out_wr, out_ctl, out_data);
        end
        nwr = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_wr) nwr++;
        end
        rst = 0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 8'(8'hC0 + i));
            if (out_wr) nwr++;
        end
        for (int c = 1; c < TO; c++) begin
            step(0, 0, 8'h00);
            if (out_wr) nwr++;
        end
        n_checks++;
        if (nwr !== 0) begin n_errors++; $display("FAIL resetmid_flush writes=%0d required 0", nwr); end
        step(0, 0, 8'h00);
        n_checks++;
        if (out_wr !== 1'b1 || out_ctl !== 32'hC300_0000 || out_data[479:456] !== 24'hC0C1C2) begin
            n_errors++;
            $display("FAIL resetmid_newpkt wr=%b ctl=%h required 1/c3000000 top=%h", out_wr, out_ctl, out_data[479:456]);
        end
    endtask

    task automatic test_random();
        int pct_dv[4];
        do_reset();
        pct_dv[0] = 100; pct_dv[1] = 90; pct_dv[2] = 50; pct_dv[3] = 3;
        for (int s = 0; s < 40; s++) begin
            int len, p;
            len = int'($urandom_range(20, 120));
            p   = pct_dv[$urandom_range(0, 3)];
            for (int c = 0; c < len; c++) begin
                bit dv, np;
                dv = ($urandom_range(0, 99) < p);
                np = ($urandom_range(0, 99) < 2);
                step(dv, np, 8'($urandom));
                n_checks++;
                if (out_wr !== exp_wr || out_ctl !== exp_ctl || out_data !== exp_data) begin
                    n_errors++;
                    $display("FAIL random seg %0d cyc %0d wr=%b/%b ctl=%h/%h data=%h/%h",
                             s, c, out_wr, exp_wr, out_ctl, exp_ctl, out_data, exp_data);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_single60();
        test_64bytes();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
